// File: rtl/muldiv_pkg.sv
// Shared definitions for the multiply/divide sequencer: state encoding,
// default timing parameters and the iteration-counter width.
package muldiv_pkg;

  localparam int DIV_ITERS_DEF  = 32;
  localparam int MUL_CYCLES_DEF = 2;

  // One spare bit beyond what DIV_ITERS-1 needs (6 bits at the default 32).
  localparam int CNT_W_DEF = $clog2(DIV_ITERS_DEF + 1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_DRUN  = 3'd1,
    ST_DFIX  = 3'd2,
    ST_MWAIT = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

endpackage

// File: rtl/muldiv_iter_cnt.sv
// Clearable up-counter with terminal-count compare. It stops at the terminal
// value instead of wrapping. Shared by the divide iterations and the
// multiplier pipeline wait.
module muldiv_iter_cnt #(
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic [CNT_W-1:0] term,
  output logic [CNT_W-1:0] cnt,
  output logic             at_term
);

  assign at_term = (cnt == term);

  // Count up while enabled; hold at the terminal value; clear on request.
  // NOTE: registers use non-blocking (<=) so every flop samples the pre-edge
  // values of its neighbours; blocking here would create order-dependent races.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && !at_term) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/muldiv_ctrl.sv
// Sequencer for the shared multi-cycle multiply/divide unit behind the
// E-stage ALU. Accepts one op at a time, steps the radix-2 divider or waits
// out the multiplier pipeline, holds the result until E->M can take it, and
// issues exactly one HI/LO write per completed op.
// Optional build macro: MULDIV_EARLY_EXIT_EN -- trivial divides (dp_trivial
// in the accept cycle) skip the iteration phase and go straight to DFIX.
module muldiv_ctrl
  import muldiv_pkg::*;
#(
  parameter int DIV_ITERS  = DIV_ITERS_DEF,
  parameter int MUL_CYCLES = MUL_CYCLES_DEF,
  parameter int CNT_W      = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             op_valid,
  input  logic             op_is_div,
  input  logic             op_sign,
  input  logic             flush,
  input  logic             stall_down,
  input  logic             dp_trivial,
  output logic             dp_load,
  output logic             dp_step,
  output logic [CNT_W-1:0] dp_iter,
  output logic             dp_fix,
  output logic             dp_abort,
  output logic             dp_sign,
  output logic             mul_en,
  output logic             stall_req,
  output logic             res_valid,
  output logic             hilo_we,
  output logic             busy
);

  localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(DIV_ITERS - 1);
  localparam logic [CNT_W-1:0] MUL_LAST = CNT_W'(MUL_CYCLES - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt;
  logic             cnt_at_term;
  logic             cnt_en;
  logic [CNT_W-1:0] cnt_term;
  logic             accept;
  logic             early_exit;
  logic             sign_q;

`ifdef MULDIV_EARLY_EXIT_EN
  assign early_exit = op_is_div & dp_trivial;
`else
  logic unused_trivial;
  assign unused_trivial = dp_trivial;
  assign early_exit     = 1'b0;
`endif

  // Reset is folded in so the accept-path outputs are quiet while rst is high,
  // even if op_valid is asserted.
  assign accept  = op_valid & ~flush & ~rst;
  assign busy    = (state_q != ST_IDLE);
  assign dp_sign = sign_q;

  // Iteration counter: cleared on every state change, so each state starts at 0.
  muldiv_iter_cnt #(.CNT_W(CNT_W)) u_iter_cnt (
    .clk     (clk),
    .rst     (rst),
    .clr     (state_d != state_q),
    .en      (cnt_en),
    .term    (cnt_term),
    .cnt     (cnt),
    .at_term (cnt_at_term)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Operation sign: captured at accept, cleared whenever we return to IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sign_q <= 1'b0;
    end else if (dp_load) begin
      sign_q <= op_sign;
    end else if (state_d == ST_IDLE) begin
      sign_q <= 1'b0;
    end
  end

  // Next-state and output decode; abort (flush or lost request) overrides last.
  always_comb begin
    // NOTE: every output gets a default before the case so no path through
    // the block leaves a signal unassigned, which would infer a latch.
    state_d   = state_q;
    dp_load   = 1'b0;
    dp_step   = 1'b0;
    dp_iter   = '0;
    dp_fix    = 1'b0;
    dp_abort  = 1'b0;
    mul_en    = 1'b0;
    stall_req = 1'b0;
    res_valid = 1'b0;
    hilo_we   = 1'b0;
    cnt_en    = 1'b0;
    cnt_term  = '0;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          dp_load   = 1'b1;
          stall_req = 1'b1;
          if (early_exit)     state_d = ST_DFIX;
          else if (op_is_div) state_d = ST_DRUN;
          else                state_d = ST_MWAIT;
        end
      end
      ST_DRUN: begin
        dp_step   = 1'b1;
        dp_iter   = cnt;
        stall_req = 1'b1;
        cnt_en    = 1'b1;
        cnt_term  = DIV_LAST;
        if (cnt_at_term) state_d = ST_DFIX;
      end
      ST_DFIX: begin
        dp_fix    = 1'b1;
        stall_req = 1'b1;
        state_d   = ST_DONE;
      end
      ST_MWAIT: begin
        mul_en    = 1'b1;
        stall_req = 1'b1;
        cnt_en    = 1'b1;
        cnt_term  = MUL_LAST;
        if (cnt_at_term) state_d = ST_DONE;
      end
      ST_DONE: begin
        res_valid = 1'b1;
        if (!stall_down) begin
          hilo_we = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // In DONE the instruction has already left E, so only flush aborts there.
    if (state_q != ST_IDLE) begin
      if (flush || (!op_valid && state_q != ST_DONE)) begin
        dp_abort = 1'b1;
        hilo_we  = 1'b0;
        state_d  = ST_IDLE;
      end
    end
  end

endmodule
